// File: rtl/dsm_mod_multi.sv
// Purpose : NUM_CH independent 1-bit delta-sigma modulators (order 1 or 2) sharing a
//           programmable oversampling tick, fed through a one-deep sample holding register.
// Latency : a sample accepted before tick n is loaded into the loop at tick n and first
//           shapes pwm at tick n+1 (one tick input-to-loop latency).
// Backpr. : in_ready = !pending; the holding register frees only at a tick. A tick that finds
//           it empty sets sticky underrun and reuses the previous sample.
//
// Ports   : clock/reset (async, active-low), en (freezes counter, integrators, pwm),
//           in_valid/in_ready/in_data (channel k at [k*WIDTH +: WIDTH], signed),
//           status_clr (clears sticky flags, wins over a same-cycle set),
//           pwm[NUM_CH] (1 = +FS level), tick (one cycle after each pwm update),
//           underrun, sat (sticky).
// Option  : define DSM_DITHER_EN to add a 16-bit LFSR dither of -8..+7 LSB to every
//           channel's input at each tick.
module dsm_mod_multi #(
  parameter int WIDTH   = 20,
  parameter int NUM_CH  = 2,
  parameter int ORDER   = 2,
  parameter int OSR_DIV = 1,
  parameter int GUARD   = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic                    status_clr,
  output logic [NUM_CH-1:0]       pwm,
  output logic                    tick,
  output logic                    underrun,
  output logic                    sat
);

  localparam int AW = WIDTH + GUARD;  // integrator width
  localparam int SW = AW + 2;         // unclipped sum width
  localparam int CW = 16;             // tick counter width (OSR_DIV <= 65535)

  localparam logic signed [SW-1:0] FS_S  = {{(SW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] MAX_S = {3'b000, {(AW-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S = {3'b111, {(AW-1){1'b0}}};

  generate
    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
      $error("dsm_mod_multi: ORDER must be 1 or 2");
    end
    if (OSR_DIV < 1 || OSR_DIV > 65535) begin : g_bad_osr
      $error("dsm_mod_multi: OSR_DIV must be in 1..65535");
    end
  endgenerate

  // ---------------------------------------------------------------- state
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    tick_q, tick_d;
  logic                    pending_q, pending_d;
  logic [NUM_CH*WIDTH-1:0] hold_q, hold_d;
  logic [NUM_CH*WIDTH-1:0] x_q, x_d;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;
  logic                    underrun_q, underrun_d;
  logic                    sat_q, sat_d;
  logic signed [AW-1:0]    a1_q [NUM_CH];
  logic signed [AW-1:0]    a2_q [NUM_CH];

  // ---------------------------------------------------------------- control
  logic tick_fire;
  logic accept;

  assign tick_fire = en && (cnt_q == CW'(OSR_DIV - 1));
  assign accept    = in_valid && !pending_q;
  assign in_ready  = !pending_q;

  // ---------------------------------------------------------------- dither
  logic signed [SW-1:0] dith;

`ifdef DSM_DITHER_EN
  logic [15:0]       lfsr_q, lfsr_d;
  logic signed [4:0] dith5;

  always_comb begin
    lfsr_d = lfsr_q;
    if (tick_fire) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  // Dither comes from the current LFSR value; it advances on the same tick.
  assign dith5 = $signed({1'b0, lfsr_q[3:0]}) - 5'sd8;
  assign dith  = {{(SW-5){dith5[4]}}, dith5};
`else
  assign dith = '0;
`endif

  // ---------------------------------------------------------------- loop datapath
  logic signed [SW-1:0] xs [NUM_CH];
  logic signed [SW-1:0] fb [NUM_CH];
  logic signed [SW-1:0] s1 [NUM_CH];
  logic signed [SW-1:0] s2 [NUM_CH];
  logic signed [AW-1:0] a1n [NUM_CH];
  logic signed [AW-1:0] a2n [NUM_CH];
  logic [NUM_CH-1:0]    clip1, clip2, pwm_n;

  always_comb begin
    clip1 = '0;
    clip2 = '0;
    pwm_n = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      xs[k] = $signed({{(SW-WIDTH){x_q[k*WIDTH+WIDTH-1]}}, x_q[k*WIDTH +: WIDTH]}) + dith;
      fb[k] = pwm_q[k] ? FS_S : -FS_S;

      s1[k] = $signed({{2{a1_q[k][AW-1]}}, a1_q[k]}) + xs[k] - fb[k];
      if (s1[k] > MAX_S) begin
        a1n[k]   = MAX_S[AW-1:0];
        clip1[k] = 1'b1;
      end else if (s1[k] < MIN_S) begin
        a1n[k]   = MIN_S[AW-1:0];
        clip1[k] = 1'b1;
      end else begin
        a1n[k] = s1[k][AW-1:0];
      end

      // Second stage uses the freshly clipped first integrator, gain 2 on feedback.
      s2[k] = $signed({{2{a2_q[k][AW-1]}}, a2_q[k]})
            + $signed({{2{a1n[k][AW-1]}}, a1n[k]})
            - (fb[k] <<< 1);
      if (s2[k] > MAX_S) begin
        a2n[k]   = MAX_S[AW-1:0];
        clip2[k] = 1'b1;
      end else if (s2[k] < MIN_S) begin
        a2n[k]   = MIN_S[AW-1:0];
        clip2[k] = 1'b1;
      end else begin
        a2n[k] = s2[k][AW-1:0];
      end

      pwm_n[k] = (ORDER == 1) ? ~a1n[k][AW-1] : ~a2n[k][AW-1];
    end
  end

  // ---------------------------------------------------------------- next state
  logic any_clip;
  assign any_clip = (|clip1) || ((ORDER == 2) && (|clip2));

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = tick_fire ? '0 : cnt_q + 1'b1;

    tick_d = tick_fire;

    hold_d    = accept ? in_data : hold_q;
    pending_d = pending_q;
    x_d       = x_q;
    if (tick_fire && pending_q) begin
      x_d       = hold_q;
      pending_d = 1'b0;
    end else if (accept) begin
      // Also covers accept coinciding with an empty-register tick: it waits for the next tick.
      pending_d = 1'b1;
    end

    pwm_d = tick_fire ? pwm_n : pwm_q;

    underrun_d = status_clr ? 1'b0 : (underrun_q || (tick_fire && !pending_q));
    sat_d      = status_clr ? 1'b0 : (sat_q || (tick_fire && any_clip));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      pending_q  <= 1'b0;
      hold_q     <= '0;
      x_q        <= '0;
      pwm_q      <= '0;
      underrun_q <= 1'b0;
      sat_q      <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        a1_q[k] <= '0;
        a2_q[k] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      x_q        <= x_d;
      pwm_q      <= pwm_d;
      underrun_q <= underrun_d;
      sat_q      <= sat_d;
      for (int k = 0; k < NUM_CH; k++) begin
        if (tick_fire) begin
          a1_q[k] <= a1n[k];
          a2_q[k] <= a2n[k];
        end
      end
    end
  end

  assign pwm      = pwm_q;
  assign tick     = tick_q;
  assign underrun = underrun_q;
  assign sat      = sat_q;

endmodule

// File: doc/dsm_mod_multi.md
Name: dsm_mod_multi

Overview:
- Parametrised successor to the single-channel 20-bit DSM: NUM_CH independent 1-bit delta-sigma modulators, each selectable as first or second order.
- Each modulator is clocked by a shared programmable oversampling tick.
- Input samples arrive on a valid/ready interface and pass through a one-deep holding register; underrun and saturation are reported as sticky flags.
- Sits between the sample source (filter or testbench file reader) and the pad-level 1-bit PWM drivers.

Parameters:
- WIDTH, 20: signed input sample width; full scale FS = 2^(WIDTH-1).
- NUM_CH, 2: number of modulator channels.
- ORDER, 2: loop order; legal values 1 or 2, any other value is an elaboration error.
- OSR_DIV, 1: clocks per modulator tick; legal range 1..65535.
- GUARD, 3: integrator guard bits; accumulator width AW = WIDTH+GUARD.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous assert, active-low; all state is cleared while low.
- en  in  1  when low: tick counter, integrators and pwm hold their values.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  holding register empty.
- in_data  in  NUM_CH*WIDTH  signed samples; channel k at [k*WIDTH +: WIDTH].
- status_clr  in  1  one-cycle pulse that clears underrun and sat.
- pwm  out  NUM_CH  1 = +1 level, 0 = -1 level.
- tick  out  1  registered; high for the one cycle following each pwm update edge.
- underrun  out  1  sticky.
- sat  out  1  sticky.

Behaviour:
- Reset values:
  - pwm=0, tick=0, underrun=0, sat=0.
  - All integrators 0, x_reg 0, tick counter 0, pending=0.
  - in_ready is therefore 1.
- Tick counter:
  - Increments while en=1 and wraps from OSR_DIV-1 to 0.
  - A tick fires on any enabled cycle where count==OSR_DIV-1.
  - With OSR_DIV=1, every enabled cycle is a tick.
- Handshake:
  - in_ready = !pending (combinational).
  - Accept = in_valid && in_ready; on accept, hold_reg <= in_data and pending <= 1.
  - At a tick with pending=1: x_reg <= hold_reg and pending <= 0. The tick itself uses the old x_reg, so input-to-loop latency is one tick.
  - At a tick with pending=0: x_reg is held and underrun is set. This also applies when an accept happens in the same cycle as the tick; that sample becomes pending for the next tick.
  - in_data changing while in_valid=0 has no effect.
- Loop arithmetic, per channel at each tick (signed; fb = pwm ? +FS : -FS; sat() clips to [-2^(AW-1), 2^(AW-1)-1]):
  - ORDER=1: a1' = sat(a1 + x - fb); pwm' = (a1' >= 0).
  - ORDER=2: a1' = sat(a1 + x - fb); a2' = sat(a2 + a1' - 2*fb); pwm' = (a2' >= 0).
  - Any clip in any channel sets sat. The unclipped sum must be computed at AW+2 bits.
- Ones density in steady state = (1 + x/FS)/2. The second-order loop is specified stable for |x| <= FS/2; larger inputs are allowed and are bounded by saturation.
- tick <= tick_fire on every clock; tick is low while en=0.
- status_clr has priority over a same-cycle set: the flag reads 0 after that cycle.
- en deasserted mid-count: the counter freezes and resumes from the same value. The handshake is still live, so one sample can be accepted while disabled.
- reset asserted mid-operation: immediate return to reset values, no clock required. Deassertion is synchronised externally.

Optional Feature:
- DSM_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) seeds to 16'hACE1 on reset and advances once per tick.
  - The signed value {lfsr[3:0]} - 8 (range -8..+7 LSB) is added to x for all channels at that tick, before the a1 sum.
- DSM_DITHER_EN undefined: no LFSR, dither term is 0, and results are bit-exact to the equations above.

Test Plan:
- Reset, then ORDER=1, WIDTH=16, OSR_DIV=1, one sample x=0 -> pwm sequence after the first two ticks is 1,1,0,1,0,1,... (strict alternation); underrun=1 from tick 1 onward.
- ORDER=2, WIDTH=16, x=+16384 streamed every tick -> ones count over 1024 ticks = 768±2, underrun=0, sat=0.
- NUM_CH=2, ch0=-16384, ch1=+8192, OSR_DIV=4 -> tick every 4th cycle; over 512 ticks ch0 ones = 128±2 and ch1 ones = 320±2.
- Sample accepted in the same cycle as a tick with pending=0 -> underrun=1, new value first used two ticks later, in_ready=0 until the next tick.
- x=+32767 with ORDER=2 -> sat=1 within 64 ticks; status_clr pulse -> sat=0 next cycle; status_clr coincident with a new clip -> sat=0.
- Assert reset asynchronously between clock edges mid-stream -> pwm, tick, underrun, sat and in_ready equal 0,0,0,0,1 before the next rising edge.
